// File: rtl/matrix_elementwise_add_pkg.sv
// Shared definitions for the element-wise matrix add engine: memory request
// codes, header layout, FSM states and the engine's operation code.
package matrix_elementwise_add_pkg;

  localparam int DEF_TYPE_BW   = 32;
  localparam int DEF_MEM_WORDS = 256;

  localparam logic [2:0] OPCODE_EWADD = 3'd3;

  localparam logic [31:0] HDR_ROWS  = 32'd0;
  localparam logic [31:0] HDR_COLS  = 32'd1;
  localparam logic [31:0] DATA_BASE = 32'd2;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ROWS,
    ST_RD_COLS,
    ST_CHECK,
    ST_RD_A,
    ST_RD_B,
    ST_WR_C,
    ST_FIN
  } state_e;

endpackage

// File: rtl/matrix_elementwise_add_if.sv
// Single-outstanding-request SRAM port between a compute engine (master)
// and the top-level memory controller (slave).
interface matrix_elementwise_add_if
  import matrix_elementwise_add_pkg::*;
#(
  parameter int TYPE_BW = DEF_TYPE_BW
);
  logic [31:0]        addr_o;
  logic [TYPE_BW-1:0] data_o;
  logic [31:0]        data_i;
  logic               mem_opdone;
  logic [1:0]         mem_operation;

  modport master (
    output addr_o,
    output data_o,
    output mem_operation,
    input  data_i,
    input  mem_opdone
  );

  modport slave (
    input  addr_o,
    input  data_o,
    input  mem_operation,
    output data_i,
    output mem_opdone
  );
endinterface

// File: rtl/matrix_elementwise_add_sat_add.sv
// Combinational signed adder that clamps to the TYPE_BW two's complement range
// instead of wrapping; shared with the convolution accumulator.
module sat_add
  import matrix_elementwise_add_pkg::*;
#(
  parameter int TYPE_BW = DEF_TYPE_BW
) (
  input  logic signed [TYPE_BW-1:0] a_i,
  input  logic signed [TYPE_BW-1:0] b_i,
  output logic signed [TYPE_BW-1:0] sum_o
);

  // Overflow shows up as the two top bits of the one-bit-wider sum disagreeing.
  function automatic logic signed [TYPE_BW-1:0] saturate(input logic signed [TYPE_BW:0] x);
    if (x[TYPE_BW] != x[TYPE_BW-1])
      return x[TYPE_BW] ? {1'b1, {(TYPE_BW-1){1'b0}}} : {1'b0, {(TYPE_BW-1){1'b1}}};
    return x[TYPE_BW-1:0];
  endfunction

  logic signed [TYPE_BW:0] wide;

  assign wide  = (TYPE_BW+1)'(a_i) + (TYPE_BW+1)'(b_i);
  assign sum_o = saturate(wide);

endmodule

// File: rtl/matrix_elementwise_add.sv
// Element-wise saturating matrix add engine: reads a rows/cols header and two
// operand matrices from SRAM and writes C = sat(A+B) behind them.
module matrix_elementwise_add
  import matrix_elementwise_add_pkg::*;
#(
  parameter int TYPE_BW   = DEF_TYPE_BW,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic done,
  output logic error,
  matrix_elementwise_add_if.master mem
);

  state_e  state_q;
  mem_op_e op_q;
  mem_op_e req_op_d;
  logic    pend_q;
  logic    done_q;
  logic    error_q;

  logic [31:0] addr_q;
  logic [31:0] req_addr_d;
  logic [31:0] i_q;
  logic [31:0] n_q;
  logic [31:0] n_d;
  logic [31:0] b_base_q;
  logic [31:0] c_base_q;
  logic [33:0] span_d;
  logic [15:0] rows_q;
  logic [15:0] cols_q;

  logic signed [TYPE_BW-1:0] a_q;
  logic signed [TYPE_BW-1:0] b_q;
  logic signed [TYPE_BW-1:0] data_q;
  logic signed [TYPE_BW-1:0] sum_d;

  sat_add #(
    .TYPE_BW(TYPE_BW)
  ) u_sat_add (
    .a_i  (a_q),
    .b_i  (b_q),
    .sum_o(sum_d)
  );

  // The only multiply; per-element addresses are base + i.
  assign n_d    = 32'(rows_q) * 32'(cols_q);
  assign span_d = 34'(n_d) * 34'd3 + 34'(DATA_BASE);

  always_comb begin
    req_addr_d = HDR_ROWS;
    req_op_d   = MEM_READ;
    case (state_q)
      ST_RD_COLS: req_addr_d = HDR_COLS;
      ST_RD_A:    req_addr_d = DATA_BASE + i_q;
      ST_RD_B:    req_addr_d = b_base_q + i_q;
      ST_WR_C: begin
        req_addr_d = c_base_q + i_q;
        req_op_d   = MEM_WRITE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      op_q    <= MEM_NONE;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      i_q     <= '0;
    end else if (state_q != ST_IDLE && !enable) begin
      // Abort (or FIN release): a same-cycle opdone is deliberately dropped.
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      op_q    <= MEM_NONE;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && !done_q) state_q <= ST_RD_ROWS;
        end
        ST_CHECK: begin
          n_q      <= n_d;
          b_base_q <= DATA_BASE + n_d;
          c_base_q <= DATA_BASE + (n_d << 1);
          i_q      <= '0;
          if (n_d == 32'd0) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            error_q <= 1'b0;
          end else if (span_d > 34'(MEM_WORDS)) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            state_q <= ST_RD_A;
          end
        end
        ST_FIN: ;
        default: begin
          // Memory states: the first cycle in a state is always an idle (00)
          // cycle, which gives the controller time to clear its opdone.
          if (!pend_q) begin
            pend_q <= 1'b1;
            op_q   <= req_op_d;
            addr_q <= req_addr_d;
            if (req_op_d == MEM_WRITE) data_q <= sum_d;
          end else if (mem.mem_opdone) begin
            pend_q <= 1'b0;
            op_q   <= MEM_NONE;
            case (state_q)
              ST_RD_ROWS: begin
                rows_q  <= mem.data_i[15:0];
                state_q <= ST_RD_COLS;
              end
              ST_RD_COLS: begin
                cols_q  <= mem.data_i[15:0];
                state_q <= ST_CHECK;
              end
              ST_RD_A: begin
                a_q     <= mem.data_i[TYPE_BW-1:0];
                state_q <= ST_RD_B;
              end
              ST_RD_B: begin
                b_q     <= mem.data_i[TYPE_BW-1:0];
                state_q <= ST_WR_C;
              end
              ST_WR_C: begin
                i_q <= i_q + 32'd1;
                if (i_q + 32'd1 == n_q) begin
                  state_q <= ST_FIN;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_RD_A;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign done              = done_q;
  assign error             = error_q;
  assign mem.addr_o        = addr_q;
  assign mem.data_o        = data_q;
  assign mem.mem_operation = op_q;

endmodule

// File: tb/tb_matrix_elementwise_add.sv
// Directed + randomized bench for matrix_elementwise_add: a behavioural SRAM
// controller with random latency and a plain-arithmetic saturating-sum model.
module tb_matrix_elementwise_add;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic clk;
  logic reset;
  logic enable;
  logic done;
  logic error;

  matrix_elementwise_add_if #(.TYPE_BW(32)) mif ();

  matrix_elementwise_add #(
    .TYPE_BW  (32),
    .MEM_WORDS(256)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .done  (done),
    .error (error),
    .mem   (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  int checks;
  int errors;

  // controller model state
  int          lat_min, lat_max, lat;
  bit          busy, need_gap;
  logic [31:0] cap_addr, cap_data;
  logic [1:0]  cap_op;
  int          rd_cnt, el_rd_cnt, hdr0_cnt, wr_cnt;
  int          stab_viol, gap_viol, oob_viol;
  bit          abort_arm, abort_hit;
  logic [31:0] abort_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_ref(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > SMAX) return 32'h7FFF_FFFF;
    if (s < SMIN) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] rand_elem();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      1:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Memory controller behaviour, evaluated once per cycle at the falling edge.
  task automatic respond();
    mif.mem_opdone = 1'b0;
    mif.data_i     = $urandom;
    if (reset) begin
      busy     = 1'b0;
      need_gap = 1'b0;
      return;
    end
    if (need_gap) begin
      need_gap = 1'b0;
      if (mif.mem_operation != 2'b00) gap_viol++;
    end
    if (mif.mem_operation == 2'b00) begin
      busy = 1'b0;
      return;
    end
    if (!busy) begin
      busy     = 1'b1;
      lat      = $urandom_range(lat_max, lat_min);
      cap_addr = mif.addr_o;
      cap_op   = mif.mem_operation;
      cap_data = mif.data_o;
    end else if (mif.addr_o != cap_addr || mif.mem_operation != cap_op ||
                 (cap_op == 2'b11 && mif.data_o != cap_data)) begin
      stab_viol++;
    end
    if (lat > 1) begin
      lat--;
      return;
    end
    busy           = 1'b0;
    need_gap       = 1'b1;
    mif.mem_opdone = 1'b1;
    if (mif.addr_o >= 32'd256) begin
      oob_viol++;
      return;
    end
    case (mif.mem_operation)
      2'b01: begin
        mif.data_i = mem[mif.addr_o[7:0]];
        rd_cnt++;
        if (mif.addr_o >= 32'd2) el_rd_cnt++;
        if (mif.addr_o == 32'd0) hdr0_cnt++;
        if (abort_arm && mif.addr_o == abort_addr) begin
          enable    = 1'b0;
          abort_hit = 1'b1;
        end
      end
      2'b11: begin
        mem[mif.addr_o[7:0]] = mif.data_o;
        wr_cnt++;
      end
      default: stab_viol++;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [31:0] rw, input logic [31:0] cw, input int n);
    for (int k = 0; k < 256; k++) mem[k] = 32'hDEAD_BEEF;
    mem[0] = rw;
    mem[1] = cw;
    for (int k = 0; k < n && 2 + n + k < 256; k++) begin
      mem[2 + k]     = rand_elem();
      mem[2 + n + k] = rand_elem();
    end
  endtask

  task automatic run_op(input int budget);
    int cyc;
    cyc    = 0;
    enable = 1'b1;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("done_raised", 64'(done), 64'(1));
  endtask

  task automatic release_op();
    enable = 1'b0;
    tick();
    chk("done_cleared", 64'(done), 64'(0));
    chk("error_cleared", 64'(error), 64'(0));
  endtask

  task automatic check_c(input string tag, input int n);
    for (int k = 0; k < n; k++)
      chk(tag, 64'(mem[2 + 2*n + k]), 64'(sat_ref(mem[2 + k], mem[2 + n + k])));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_op", 64'(mif.mem_operation), 64'(0));
    chk("rst_addr", 64'(mif.addr_o), 64'(0));
    chk("rst_data", 64'(mif.data_o), 64'(0));
  endtask

  int rd0, el0, wr0, h0, cyc;

  initial begin
    checks = 0; errors = 0;
    rd_cnt = 0; el_rd_cnt = 0; hdr0_cnt = 0; wr_cnt = 0;
    stab_viol = 0; gap_viol = 0; oob_viol = 0;
    busy = 1'b0; need_gap = 1'b0; lat = 0;
    abort_arm = 1'b0; abort_hit = 1'b0; abort_addr = '0;
    lat_min = 1; lat_max = 3;
    mif.mem_opdone = 1'b0;
    mif.data_i     = '0;
    enable = 1'b0;
    reset  = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 32'hDEAD_BEEF;

    // reset state
    tick(); tick();
    chk_reset_outputs();
    reset = 1'b0;
    tick();
    chk("idle_op", 64'(mif.mem_operation), 64'(0));

    // 2x2 directed add
    setup(32'd2, 32'd2, 4);
    mem[2] = 32'd1;  mem[3] = 32'd2;  mem[4] = 32'd3;  mem[5] = 32'd4;
    mem[6] = 32'd10; mem[7] = 32'd20; mem[8] = 32'd30; mem[9] = 32'd40;
    rd0 = rd_cnt; el0 = el_rd_cnt; wr0 = wr_cnt;
    run_op(500);
    chk("2x2_error", 64'(error), 64'(0));
    chk("2x2_c0", 64'(mem[10]), 64'(11));
    chk("2x2_c1", 64'(mem[11]), 64'(22));
    chk("2x2_c2", 64'(mem[12]), 64'(33));
    chk("2x2_c3", 64'(mem[13]), 64'(44));
    chk("2x2_elem_reads", 64'(el_rd_cnt - el0), 64'(8));
    chk("2x2_total_reads", 64'(rd_cnt - rd0), 64'(10));
    chk("2x2_writes", 64'(wr_cnt - wr0), 64'(4));
    chk("2x2_untouched", 64'(mem[14]), 64'(32'hDEAD_BEEF));
    release_op();

    // saturation at both ends
    setup(32'd1, 32'd2, 2);
    mem[2] = 32'h7FFF_FFFF; mem[3] = 32'h8000_0000;
    mem[4] = 32'd1;         mem[5] = 32'hFFFF_FFFF;
    run_op(500);
    chk("sat_pos", 64'(mem[6]), 64'(32'h7FFF_FFFF));
    chk("sat_neg", 64'(mem[7]), 64'(32'h8000_0000));
    release_op();

    // randomized 3x4
    setup(32'd3, 32'd4, 12);
    wr0 = wr_cnt;
    run_op(2000);
    chk("r3x4_error", 64'(error), 64'(0));
    chk("r3x4_writes", 64'(wr_cnt - wr0), 64'(12));
    check_c("r3x4_c", 12);
    release_op();

    // empty header
    setup(32'd0, 32'd5, 0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(500);
    chk("empty_error", 64'(error), 64'(0));
    chk("empty_reads", 64'(rd_cnt - rd0), 64'(2));
    chk("empty_writes", 64'(wr_cnt - wr0), 64'(0));
    release_op();

    // oversize header: 2+300 > 256
    setup(32'd10, 32'd10, 0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(500);
    chk("over_error", 64'(error), 64'(1));
    chk("over_reads", 64'(rd_cnt - rd0), 64'(2));
    chk("over_writes", 64'(wr_cnt - wr0), 64'(0));
    release_op();

    // just over the bound: 85x1 needs 257 words
    setup(32'd85, 32'd1, 0);
    wr0 = wr_cnt;
    run_op(500);
    chk("bound_over_error", 64'(error), 64'(1));
    chk("bound_over_writes", 64'(wr_cnt - wr0), 64'(0));
    release_op();

    // largest fitting size, upper header bits ignored (rows word = 0xFFFF0001)
    setup(32'hFFFF_0001, 32'd84, 84);
    wr0 = wr_cnt;
    run_op(5000);
    chk("bound_fit_error", 64'(error), 64'(0));
    chk("bound_fit_writes", 64'(wr_cnt - wr0), 64'(84));
    check_c("bound_fit_c", 84);
    release_op();

    // abort on the 3rd element's RD_B opdone (2x3, B[2] at word 10, C[2] at 16)
    setup(32'd2, 32'd3, 6);
    wr0 = wr_cnt;
    abort_addr = 32'd10;
    abort_arm  = 1'b1;
    abort_hit  = 1'b0;
    enable     = 1'b1;
    cyc = 0;
    while (!abort_hit && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("abort_reached", 64'(abort_hit), 64'(1));
    chk("abort_op_none", 64'(mif.mem_operation), 64'(0));
    abort_arm = 1'b0;
    tick(); tick(); tick();
    chk("abort_no_req", 64'(mif.mem_operation), 64'(0));
    chk("abort_done_low", 64'(done), 64'(0));
    chk("abort_no_c2", 64'(mem[16]), 64'(32'hDEAD_BEEF));
    chk("abort_writes", 64'(wr_cnt - wr0), 64'(2));
    h0 = hdr0_cnt;
    run_op(1000);
    chk("restart_hdr_read", 64'(hdr0_cnt - h0), 64'(1));
    check_c("restart_c", 6);
    release_op();

    // slow controller, reset asserted while a write is pending
    lat_min = 1; lat_max = 7;
    setup(32'd2, 32'd2, 4);
    enable = 1'b1;
    cyc = 0;
    while (mif.mem_operation != 2'b11 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("slow_write_seen", 64'(mif.mem_operation), 64'(2'b11));
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    chk_reset_outputs();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("post_reset_quiet", 64'(mif.mem_operation), 64'(0));
    setup(32'd2, 32'd2, 4);
    run_op(1000);
    check_c("slow_c", 4);
    release_op();

    // protocol invariants over the whole run
    chk("addr_data_stable", 64'(stab_viol), 64'(0));
    chk("idle_gap", 64'(gap_viol), 64'(0));
    chk("addr_in_range", 64'(oob_viol), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
